// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and helpers for the pipeline hazard controller
// Purpose: FSM state encodings, register-index width, zero-register constant and the
//          operand/destination match helper used by the load-use detector.
// Ports:   none (package).
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    // Controller FSM states
    localparam logic RUN     = 1'b0;
    localparam logic MD_WAIT = 1'b1;

    // True when a source operand that is actually read names the given destination.
    function automatic logic src_matches(
        input logic                 uses,
        input logic [REG_IDX_W-1:0] src,
        input logic [REG_IDX_W-1:0] dst
    );
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// rtl/pipeline_hazard_ctrl_sat_counter.sv - saturating event counter with synchronous clear
// Purpose: counts cycles where inc=1, holds at all-ones instead of wrapping.
// Ports:   clk   - clock
//          clr   - synchronous clear (active-high), wins over inc
//          inc   - count this cycle
//          count - current value
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline
// Purpose: generates hold (lock) and bubble (flush) controls for PC and the four
//          pipeline registers from load-use hazards, EX redirects, mult/div EX
//          occupancy and data-memory wait; keeps saturating stall/flush counters.
// Ports:   clk, rst                 - clock, synchronous active-high reset
//          id_rs/id_rt/id_uses_*    - source operands of the instruction in ID
//          ex_mem_read/ex_rt        - load in EX and its destination
//          ex_redirect              - taken branch/jump resolved in EX
//          ex_md_start              - first EX cycle of a mult/div op
//          mem_busy                 - data memory not ready
//          *_lock / *_flush         - per-register hold / clear controls
//          md_done                  - last stall cycle of a mult/div op
//          stall_count/flush_count  - saturating performance counters
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int PERF_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rt,
    input  logic                 ex_redirect,
    input  logic                 ex_md_start,
    input  logic                 mem_busy,
    output logic                 pc_lock,
    output logic                 if_id_lock,
    output logic                 if_id_flush,
    output logic                 id_ex_lock,
    output logic                 id_ex_flush,
    output logic                 ex_mem_lock,
    output logic                 ex_mem_flush,
    output logic                 mem_wb_flush,
    output logic                 md_done,
    output logic [PERF_W-1:0]    stall_count,
    output logic [PERF_W-1:0]    flush_count
);

    // The start cycle is itself a stall cycle, so the wait phase covers the rest.
    localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

    logic       state;
    logic [7:0] md_cnt;

    logic load_use;
    logic md_occupy;

    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      (src_matches(id_uses_rs, id_rs, ex_rt) ||
                       src_matches(id_uses_rt, id_rt, ex_rt));

    assign md_occupy = (state == MD_WAIT) || ex_md_start;

    // Strict priority: memory freeze, then mult/div occupancy, then redirect,
    // then load-use. Each cause drives only its own set of controls.
    always_comb begin
        pc_lock      = 1'b0;
        if_id_lock   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_lock   = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_lock  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        md_done      = 1'b0;
        if (!rst) begin
            // The divider keeps counting through a memory freeze, so its done
            // strobe is independent of the stall priority below.
            md_done = (state == MD_WAIT) && (md_cnt == 8'd1);
            if (mem_busy) begin
                pc_lock      = 1'b1;
                if_id_lock   = 1'b1;
                id_ex_lock   = 1'b1;
                ex_mem_lock  = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (md_occupy) begin
                pc_lock      = 1'b1;
                if_id_lock   = 1'b1;
                id_ex_lock   = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (ex_redirect) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (load_use) begin
                pc_lock      = 1'b1;
                if_id_lock   = 1'b1;
                id_ex_flush  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            md_cnt <= 8'd0;
        end else begin
            case (state)
                RUN: begin
                    // A start seen under a memory freeze is re-presented later.
                    if (ex_md_start && !mem_busy) begin
                        state  <= MD_WAIT;
                        md_cnt <= MD_LOAD;
                    end
                end
                MD_WAIT: begin
                    md_cnt <= md_cnt - 8'd1;
                    if (md_cnt == 8'd1) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state  <= RUN;
                    md_cnt <= 8'd0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (PERF_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (pc_lock),
        .count (stall_count)
    );

    sat_counter #(
        .WIDTH (PERF_W)
    ) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (if_id_flush),
        .count (flush_count)
    );

endmodule
